// File: rtl/fill_pkg.sv
// Shared definitions for the polygon fill pipeline: FSM states and screen geometry
// defaults used by the controller, the math stage and the span writer.
package fill_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int ADDR_BITS     = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/fill_addr_gen.sv
// Frame-buffer address generator: row base y*SCREEN_WIDTH plus column, truncated
// to ADDR_BITS. Purely combinational.
module fill_addr_gen #(
    parameter int X_BITS       = 10,
    parameter int Y_BITS       = 9,
    parameter int SCREEN_WIDTH = fill_pkg::SCREEN_WIDTH,
    parameter int ADDR_BITS    = fill_pkg::ADDR_BITS
) (
    input  logic [Y_BITS-1:0]    row,
    input  logic [X_BITS-1:0]    col,
    output logic [ADDR_BITS-1:0] addr
);

    logic [ADDR_BITS-1:0] row_w;
    logic [ADDR_BITS-1:0] base;

    assign row_w = ADDR_BITS'(row);

    // 640 = 512 + 128, so the standard screen needs no multiplier.
    if (SCREEN_WIDTH == 640) begin : g_shift_add
        assign base = (row_w << 9) + (row_w << 7);
    end else begin : g_mul
        assign base = row_w * ADDR_BITS'(SCREEN_WIDTH);
    end

    assign addr = base + ADDR_BITS'(col);

endmodule

// File: rtl/fill_span_writer.sv
// Pixel-write stage of the polygon fill block: latches one horizontal span and
// issues one req/ack frame-buffer write per pixel, then reports completion.
module fill_span_writer #(
    parameter int X_BITS       = 10,
    parameter int Y_BITS       = 9,
    parameter int COLOR_BITS   = 24,
    parameter int SCREEN_WIDTH = fill_pkg::SCREEN_WIDTH,
    parameter int ADDR_BITS    = fill_pkg::ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  fill_en,
    input  logic                  fill_start,
    input  logic [X_BITS-1:0]     x_left,
    input  logic [X_BITS-1:0]     x_right,
    input  logic [Y_BITS-1:0]     y,
    input  logic [Y_BITS-1:0]     y_last,
    input  logic [COLOR_BITS-1:0] color,
    input  logic                  wr_ack,
    output logic                  wr_req,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic [COLOR_BITS-1:0] wr_data,
    output logic                  fill_done,
    output logic                  all_finish,
    output logic                  busy
);

    import fill_pkg::fill_state_e;
    import fill_pkg::ST_IDLE;
    import fill_pkg::ST_SETUP;
    import fill_pkg::ST_WRITE;
    import fill_pkg::ST_DONE;

    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(SCREEN_WIDTH - 1);

    fill_state_e           state_q, state_d;
    logic [X_BITS-1:0]     x_l_q, x_l_d;
    logic [X_BITS-1:0]     x_r_q, x_r_d;
    logic [X_BITS-1:0]     x_cur_q, x_cur_d;
    logic [Y_BITS-1:0]     y_q, y_d;
    logic [Y_BITS-1:0]     y_last_q, y_last_d;
    logic [COLOR_BITS-1:0] color_q, color_d;
    logic                  all_finish_q, all_finish_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;

    logic [X_BITS-1:0]     span_lo, span_hi, hi_clamp, col_sel;
    logic [ADDR_BITS-1:0]  addr_next;
    logic                  addr_load;
    logic                  last_row;

    assign span_lo  = (x_l_q > x_r_q) ? x_r_q : x_l_q;
    assign span_hi  = (x_l_q > x_r_q) ? x_l_q : x_r_q;
    assign hi_clamp = (span_hi > X_MAX) ? X_MAX : span_hi;
    assign last_row = (y_q == y_last_q);

    // The address register is loaded either with the first column (SETUP) or the
    // next column (WRITE), so the generator never sees the ack combinationally.
    assign col_sel = (state_q == ST_SETUP) ? span_lo : x_cur_q + X_BITS'(1);

    fill_addr_gen #(
        .X_BITS       (X_BITS),
        .Y_BITS       (Y_BITS),
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .ADDR_BITS    (ADDR_BITS)
    ) u_addr_gen (
        .row  (y_q),
        .col  (col_sel),
        .addr (addr_next)
    );

    assign wr_addr_d = addr_load ? addr_next : wr_addr_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        state_d      = state_q;
        x_l_d        = x_l_q;
        x_r_d        = x_r_q;
        x_cur_d      = x_cur_q;
        y_d          = y_q;
        y_last_d     = y_last_q;
        color_d      = color_q;
        all_finish_d = all_finish_q;
        addr_load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fill_start && fill_en) begin
                    x_l_d        = x_left;
                    x_r_d        = x_right;
                    y_d          = y;
                    y_last_d     = y_last;
                    color_d      = color;
                    all_finish_d = 1'b0;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!fill_en) begin
                    state_d = ST_IDLE;
                end else if (span_lo > X_MAX) begin
                    all_finish_d = last_row;
                    state_d      = ST_DONE;
                end else begin
                    x_l_d     = span_lo;
                    x_r_d     = hi_clamp;
                    x_cur_d   = span_lo;
                    addr_load = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // An abort only takes effect once the outstanding beat is accepted.
                if (wr_ack) begin
                    if (!fill_en) begin
                        state_d = ST_IDLE;
                    end else if (x_cur_q == x_r_q) begin
                        all_finish_d = last_row;
                        state_d      = ST_DONE;
                    end else begin
                        x_cur_d   = x_cur_q + X_BITS'(1);
                        addr_load = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!fill_en) all_finish_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            x_l_q        <= '0;
            x_r_q        <= '0;
            x_cur_q      <= '0;
            y_q          <= '0;
            y_last_q     <= '0;
            color_q      <= '0;
            all_finish_q <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            x_l_q        <= x_l_d;
            x_r_q        <= x_r_d;
            x_cur_q      <= x_cur_d;
            y_q          <= y_d;
            y_last_q     <= y_last_d;
            color_q      <= color_d;
            all_finish_q <= all_finish_d;
            wr_addr_q    <= wr_addr_d;
        end
    end

    assign wr_req     = (state_q == ST_WRITE);
    assign fill_done  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign wr_addr    = wr_addr_q;
    assign wr_data    = color_q;
    assign all_finish = all_finish_q;

endmodule

// File: tb/tb_fill_span_writer.sv
// Self-checking bench for fill_span_writer: span-level reference model (expected
// write list, done timing, all_finish) compared against the DUT every cycle.
module tb_fill_span_writer;

    localparam int XB = 10;
    localparam int YB = 9;
    localparam int CB = 24;
    localparam int AB = 19;
    localparam int SW = 640;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          fill_en;
    logic          fill_start;
    logic [XB-1:0] x_left;
    logic [XB-1:0] x_right;
    logic [YB-1:0] y;
    logic [YB-1:0] y_last;
    logic [CB-1:0] color;
    logic          wr_ack;
    logic          wr_req;
    logic [AB-1:0] wr_addr;
    logic [CB-1:0] wr_data;
    logic          fill_done;
    logic          all_finish;
    logic          busy;

    fill_span_writer #(
        .X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB), .SCREEN_WIDTH(SW), .ADDR_BITS(AB)
    ) dut (
        .clk(clk), .n_rst(n_rst), .fill_en(fill_en), .fill_start(fill_start),
        .x_left(x_left), .x_right(x_right), .y(y), .y_last(y_last), .color(color),
        .wr_ack(wr_ack), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .fill_done(fill_done), .all_finish(all_finish), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Span-level reference model
    int unsigned   exp_q[$];
    logic [CB-1:0] exp_color = '0;
    bit            pend_done = 1'b0;
    bit            af_final = 1'b0;
    bit            exp_af = 1'b0;
    bit            busy_exp_last = 1'b0;
    bit            fe_prev = 1'b1;
    int            cyc = 0;
    int            start_cyc = 0;
    int            done_at = -1;
    int            done_cnt = 0;
    int            done_rel = -1;
    int unsigned   log_addr[$];
    int            log_rel[$];

    always @(posedge clk) cyc++;

    // Memory responder: 0 = ack tied high, 1 = fixed delay, 2 = random delay, 3 = hold low
    int ack_mode = 0;
    int ack_delay = 0;
    int wait_cnt = 0;

    initial begin
        wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 3) begin
                wr_ack = 1'b0;
            end else if (wr_req) begin
                if (wait_cnt >= ack_delay) begin
                    wr_ack = 1'b1;
                    wait_cnt = 0;
                    if (ack_mode == 2) ack_delay = int'($urandom_range(0, 3));
                end else begin
                    wr_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                wr_ack = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                wait_cnt = 0;
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        bit busy_now;
        bit req_exp;
        if (!n_rst) begin
            fe_prev = 1'b1;
        end else begin
            busy_now = pend_done || (exp_q.size() > 0);
            req_exp  = (exp_q.size() > 0) && (cyc >= start_cyc + 2);
            check("wr_req", wr_req, req_exp);
            if (wr_req && exp_q.size() > 0) begin
                check("wr_addr", wr_addr, exp_q[0]);
                check("wr_data", wr_data, exp_color);
            end
            check("fill_done", fill_done, cyc == done_at);
            check("busy", busy, busy_now);
            if (fill_done) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end
            if (cyc == done_at) begin
                pend_done = 1'b0;
                exp_af = af_final;
                done_at = -1;
            end
            if (!fe_prev) exp_af = 1'b0;
            check("all_finish", all_finish, exp_af);
            busy_exp_last = busy_now;
            if (wr_req && wr_ack && exp_q.size() > 0) begin
                log_addr.push_back(wr_addr);
                log_rel.push_back(cyc - start_cyc);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0 && pend_done) done_at = cyc + 1;
            end
            fe_prev = fill_en;
        end
    end

    task automatic start_span(input int xl, input int xr, input int yy, input int yl,
                              input logic [CB-1:0] col);
        int lo, hi;
        @(posedge clk);
        #1;
        x_left = XB'(xl);
        x_right = XB'(xr);
        y = YB'(yy);
        y_last = YB'(yl);
        color = col;
        fill_start = 1'b1;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        if (fill_en && !busy_exp_last) begin
            lo = (xl < xr) ? xl : xr;
            hi = (xl < xr) ? xr : xl;
            if (hi > SW - 1) hi = SW - 1;
            exp_q.delete();
            log_addr.delete();
            log_rel.delete();
            for (int x = lo; x <= hi; x++) exp_q.push_back(int'(yy * SW + x));
            exp_color = col;
            pend_done = 1'b1;
            af_final = (yy == yl);
            exp_af = 1'b0;
            start_cyc = cyc - 1;
            done_rel = -1;
            done_at = (exp_q.size() == 0) ? start_cyc + 2 : -1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pend_done || exp_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", pend_done || exp_q.size() > 0, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        n_rst = 1'b0;
        fill_en = 1'b0;
        fill_start = 1'b0;
        x_left = '0;
        x_right = '0;
        y = '0;
        y_last = '0;
        color = '0;

        // 1. reset with inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            fill_en = 1'($urandom_range(0, 1));
            fill_start = 1'($urandom_range(0, 1));
            x_left = XB'($urandom);
            color = CB'($urandom);
            @(negedge clk);
            check("rst_wr_req", wr_req, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_fill_done", fill_done, 0);
            check("rst_all_finish", all_finish, 0);
            check("rst_busy", busy, 0);
        end
        fill_start = 1'b0;
        fill_en = 1'b0;
        #2 n_rst = 1'b1;
        start_span(3, 8, 1, 1, 24'h123456);     // fill_en low: ignored
        repeat (3) @(negedge clk);
        check("idle_after_ignored_start", busy, 0);
        fill_en = 1'b1;
        repeat (2) @(negedge clk);

        // 2. basic span, ack tied high
        ack_mode = 0; ack_delay = 0;
        start_span(5, 9, 2, 3, 24'hFF0000);
        wait_idle(100);
        check("t2_writes", log_addr.size(), 5);
        if (log_addr.size() == 5) begin
            check("t2_first_addr", log_addr[0], 1285);
            check("t2_first_cycle", log_rel[0], 2);
            check("t2_last_addr", log_addr[4], 1289);
            check("t2_last_cycle", log_rel[4], 6);
        end
        check("t2_done_cycle", done_rel, 7);
        check("t2_all_finish", all_finish, 0);

        // 3. swapped span, ack after 3 low cycles per beat
        ack_mode = 1; ack_delay = 3;
        start_span(9, 5, 2, 3, 24'h00FF00);
        wait_idle(200);
        check("t3_writes", log_addr.size(), 5);
        for (int i = 0; i < 5 && i < log_addr.size(); i++)
            check("t3_addr", log_addr[i], 1285 + i);
        if (log_rel.size() > 0) check("t3_first_accept_cycle", log_rel[0], 5);

        // 4a. clamp on the last row
        ack_mode = 0; ack_delay = 0;
        start_span(638, 1000, 479, 479, 24'h0000FF);
        wait_idle(100);
        check("t4_writes", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("t4_addr0", log_addr[0], 307198);
            check("t4_addr1", log_addr[1], 307199);
        end
        repeat (5) @(negedge clk);
        check("t4_all_finish_held", all_finish, 1);

        // 4b. empty span
        start_span(700, 800, 10, 20, 24'hABCDEF);
        wait_idle(50);
        check("t4b_writes", log_addr.size(), 0);
        check("t4b_done_cycle", done_rel, 2);
        check("t4b_all_finish", all_finish, 0);

        // 5. abort with an outstanding beat
        ack_mode = 3;
        d0 = done_cnt;
        start_span(5, 9, 2, 2, 24'h777777);
        begin
            int n = 0;
            while (!wr_req && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("t5_req_seen", wr_req, 1);
        end
        fill_en = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        pend_done = 1'b0;
        done_at = -1;
        repeat (2) @(negedge clk);
        ack_delay = 2;
        ack_mode = 1;
        wait_idle(50);
        check("t5_writes", log_addr.size(), 1);
        if (log_addr.size() == 1) check("t5_addr", log_addr[0], 1285);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_busy", busy, 0);
        check("t5_all_finish", all_finish, 0);
        fill_en = 1'b1;
        repeat (2) @(negedge clk);

        // 6a. second start while busy is ignored
        ack_mode = 0; ack_delay = 0;
        d0 = done_cnt;
        start_span(20, 29, 5, 9, 24'h010203);
        repeat (2) @(posedge clk);
        start_span(100, 110, 6, 6, 24'h0F0F0F);
        wait_idle(100);
        check("t6_done_count", done_cnt - d0, 1);
        check("t6_writes", log_addr.size(), 10);
        if (log_addr.size() == 10) check("t6_last_addr", log_addr[9], 5 * SW + 29);

        // 6b. async reset mid-WRITE
        ack_mode = 1; ack_delay = 1;
        start_span(100, 119, 7, 7, 24'h445566);
        repeat (5) @(posedge clk);
        #2;
        n_rst = 1'b0;
        exp_q.delete();
        pend_done = 1'b0;
        done_at = -1;
        exp_af = 1'b0;
        busy_exp_last = 1'b0;
        #1;
        check("t6_rst_wr_req", wr_req, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_addr", wr_addr, 0);
        @(posedge clk);
        #3 n_rst = 1'b1;
        repeat (4) @(negedge clk);

        // random spans against the model
        for (int i = 0; i < 40; i++) begin
            int r, xl, xr, yy, yl;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                xl = int'($urandom_range(0, 720));
                xr = xl + int'($urandom_range(0, 24)) - 12;
                if (xr < 0) xr = 0;
            end else if (r < 9) begin
                xl = int'($urandom_range(600, 700));
                xr = int'($urandom_range(600, 1023));
            end else begin
                xl = int'($urandom_range(0, 1023));
                xr = int'($urandom_range(0, 1023));
            end
            yy = int'($urandom_range(0, 479));
            yl = ($urandom_range(0, 1) == 1) ? yy : int'($urandom_range(0, 479));
            ack_mode = ($urandom_range(0, 1) == 1) ? 0 : 2;
            ack_delay = (ack_mode == 0) ? 0 : int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                fill_en = 1'b0;
                start_span(xr, xl, yy, yy, CB'($urandom));
                fill_en = 1'b1;
            end
            start_span(xl, xr, yy, yl, CB'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                start_span(int'($urandom_range(0, 639)), int'($urandom_range(0, 639)),
                           int'($urandom_range(0, 479)), yy, CB'($urandom));
            end
            wait_idle(8000);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
